css_mcu0_el2_btb_update_ctl: RTL and testbench

//  Write-side (training) controller for the branch predictor arrays. Accepts resolved-branch reports

---
 rtl/css_mcu0_el2_pkg.sv | 43 ++++
 rtl/btb_addr_hash.sv | 12 +
 rtl/btb_ghr_hash.sv | 10 +
 rtl/btb_tag_hash.sv | 12 +
 rtl/css_mcu0_el2_btb_upd_fifo.sv | 61 ++++++
 rtl/css_mcu0_el2_btb_update_ctl.sv | 163 ++++++++++++++++
 tb/tb_css_mcu0_el2_btb_update_ctl.sv | 274 +++++++++++++++++++++++++++
 7 files changed

// File: rtl/css_mcu0_el2_pkg.sv
// Shared branch-predictor types and sizes for the EL2 core slice.
// Holds the BTB update packet, the invalidate-sweep states and the counter update helper.
package css_mcu0_el2_pkg;

    localparam int BTB_ADDR_HI   = 9;
    localparam int BTB_ADDR_LO   = 2;
    localparam int BTB_INDEX_W   = BTB_ADDR_HI - BTB_ADDR_LO + 1;
    localparam int BTB_BTAG_SIZE = 5;
    localparam int BHT_GHR_SIZE  = 8;
    localparam int BTB_NUM_WAYS  = 2;
    localparam int BTB_WAY_W     = (BTB_NUM_WAYS > 1) ? $clog2(BTB_NUM_WAYS) : 1;
    localparam int UPD_DEPTH     = 4;

    localparam logic [1:0] BTB_ACT_NONE  = 2'd0;
    localparam logic [1:0] BTB_ACT_ALLOC = 2'd1;
    localparam logic [1:0] BTB_ACT_INVAL = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } btb_inv_state_t;

    typedef struct packed {
        logic [BTB_INDEX_W-1:0]   index;
        logic [BTB_BTAG_SIZE-1:0] tag;
        logic [BTB_WAY_W-1:0]     way;
        logic [BTB_INDEX_W-1:0]   bht_idx;
        logic [1:0]               ctr;
        logic [1:0]               btb_act;
        logic [30:0]              tgt;
    } btb_upd_pkt_t;

    // Saturating 2-bit direction counter.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && (ctr != 2'd3)) nxt = ctr + 2'd1;
        if (!taken && (ctr != 2'd0)) nxt = ctr - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/btb_addr_hash.sv
// BTB index hash shared by fetch-side lookup and training: fold of three PC byte-address slices.
module btb_addr_hash
    import css_mcu0_el2_pkg::*;
(
    input  logic [31:1]                  pc,
    output logic [BTB_ADDR_HI:BTB_ADDR_LO] hash
);
    logic unused_pc;

    assign hash      = pc[9:2] ^ pc[17:10] ^ pc[25:18];
    assign unused_pc = ^{pc[31:26], pc[1]};
endmodule

// File: rtl/btb_ghr_hash.sv
// BHT index: BTB index folded with the global history.
module btb_ghr_hash
    import css_mcu0_el2_pkg::*;
(
    input  logic [BTB_ADDR_HI:BTB_ADDR_LO] hashin,
    input  logic [BHT_GHR_SIZE-1:0]        ghr,
    output logic [BTB_ADDR_HI:BTB_ADDR_LO] hash
);
    assign hash = hashin ^ ghr;
endmodule

// File: rtl/btb_tag_hash.sv
// BTB tag hash: fold of three PC slices above the low index bits.
module btb_tag_hash
    import css_mcu0_el2_pkg::*;
(
    input  logic [31:1]              pc,
    output logic [BTB_BTAG_SIZE-1:0] hash
);
    logic unused_pc;

    assign hash      = pc[14:10] ^ pc[19:15] ^ pc[24:20];
    assign unused_pc = ^{pc[31:25], pc[9:1]};
endmodule

// File: rtl/css_mcu0_el2_btb_upd_fifo.sv
// Circular update FIFO with wrap-bit pointers and a synchronous clear.
// The caller only pushes when not full, or when popping/clearing in the same cycle.
module css_mcu0_el2_btb_upd_fifo
    import css_mcu0_el2_pkg::*;
#(
    parameter int DEPTH = UPD_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  btb_upd_pkt_t din,
    input  logic         pop,
    output btb_upd_pkt_t dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    btb_upd_pkt_t mem_q [DEPTH];
    btb_upd_pkt_t mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A clear drops pending entries but still lets a same-cycle push land in slot 0.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push) begin
            mem_d[wr_ptr_d[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_d + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/css_mcu0_el2_btb_update_ctl.sv
// BTB/BHT training controller: hashes resolved-branch reports, queues them, drains them
// through the shared array write port, and runs the invalidate-all sweep.
module css_mcu0_el2_btb_update_ctl
    import css_mcu0_el2_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exu_br_valid,
    input  logic [30:0]              exu_br_pc,
    input  logic [30:0]              exu_br_tgt,
    input  logic                     exu_br_taken,
    input  logic                     exu_br_hit,
    input  logic [BTB_WAY_W-1:0]     exu_br_way,
    input  logic [1:0]               exu_br_ctr,
    input  logic [BHT_GHR_SIZE-1:0]  exu_br_ghr,
    input  logic                     inv_all_req,
    input  logic                     wr_gnt,
    output logic                     wr_req,
    output logic                     btb_wr_en,
    output logic [BTB_INDEX_W-1:0]   btb_wr_index,
    output logic [BTB_WAY_W-1:0]     btb_wr_way,
    output logic [BTB_BTAG_SIZE-1:0] btb_wr_tag,
    output logic                     btb_wr_valid,
    output logic [30:0]              btb_wr_tgt,
    output logic                     bht_wr_en,
    output logic [BTB_INDEX_W-1:0]   bht_wr_index,
    output logic [1:0]               bht_wr_ctr,
    output logic                     inv_busy,
    output logic                     inv_done,
    output logic                     upd_drop
);
    logic [BTB_INDEX_W-1:0]   idx_hash;
    logic [BTB_BTAG_SIZE-1:0] tag_hash;
    logic [BTB_INDEX_W-1:0]   bht_hash;
    btb_upd_pkt_t             push_pkt;
    btb_upd_pkt_t             head_pkt;
    logic                     fifo_empty, fifo_full;
    logic                     fifo_clr, push_ok, pop, sweep, drain;
    logic [1:0]               new_ctr;

    btb_inv_state_t           state_q, state_d;
    logic [BTB_INDEX_W-1:0]   idx_q, idx_d;
    logic                     inv_busy_q, inv_busy_d;
    logic                     inv_done_q, inv_done_d;

    btb_addr_hash u_addr_hash (.pc(exu_br_pc), .hash(idx_hash));
    btb_tag_hash  u_tag_hash  (.pc(exu_br_pc), .hash(tag_hash));
    btb_ghr_hash  u_ghr_hash  (.hashin(idx_hash), .ghr(exu_br_ghr), .hash(bht_hash));

    // The predicted target is not reported back, so every taken hit refreshes its entry.
    always_comb begin
        new_ctr          = ctr_next(exu_br_ctr, exu_br_taken);
        push_pkt         = '0;
        push_pkt.index   = idx_hash;
        push_pkt.tag     = tag_hash;
        push_pkt.way     = exu_br_way;
        push_pkt.bht_idx = bht_hash;
        push_pkt.ctr     = new_ctr;
        push_pkt.tgt     = exu_br_tgt;
        push_pkt.btb_act = BTB_ACT_NONE;
        if (exu_br_taken)
            push_pkt.btb_act = BTB_ACT_ALLOC;
        else if (exu_br_hit && (new_ctr == 2'd0))
            push_pkt.btb_act = BTB_ACT_INVAL;
    end

    assign sweep    = (state_q == SWEEP);
    assign drain    = (state_q == IDLE) && !fifo_empty;
    assign wr_req   = sweep || drain;
    assign pop      = drain && wr_gnt;
    assign push_ok  = exu_br_valid && (fifo_clr || !fifo_full || pop);
    assign upd_drop = exu_br_valid && !push_ok && !rst;
    assign inv_busy = inv_busy_q;
    assign inv_done = inv_done_q;

    css_mcu0_el2_btb_upd_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (push_ok),
        .din   (push_pkt),
        .pop   (pop),
        .dout  (head_pkt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Entering the sweep from IDLE or DONE discards queued updates as stale.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fifo_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (inv_all_req) begin
                    state_d  = SWEEP;
                    idx_d    = '0;
                    fifo_clr = 1'b1;
                end
            end
            SWEEP: begin
                if (inv_all_req) begin
                    idx_d = '0;
                end else if (wr_gnt) begin
                    if (idx_q == '1) state_d = DONE;
                    else             idx_d   = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (inv_all_req) begin
                    state_d  = SWEEP;
                    idx_d    = '0;
                    fifo_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        inv_busy_d = (state_d == SWEEP);
        inv_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            inv_busy_q <= 1'b0;
            inv_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            inv_busy_q <= inv_busy_d;
            inv_done_q <= inv_done_d;
        end
    end

    // During the sweep inv_busy qualifies btb_wr_en as an all-way invalidate of btb_wr_index.
    always_comb begin
        btb_wr_en    = 1'b0;
        btb_wr_index = '0;
        btb_wr_way   = '0;
        btb_wr_tag   = '0;
        btb_wr_valid = 1'b0;
        btb_wr_tgt   = '0;
        bht_wr_en    = 1'b0;
        bht_wr_index = '0;
        bht_wr_ctr   = '0;
        if (sweep) begin
            btb_wr_en    = wr_gnt;
            btb_wr_index = idx_q;
        end else if (drain) begin
            btb_wr_en    = wr_gnt && (head_pkt.btb_act != BTB_ACT_NONE);
            btb_wr_index = head_pkt.index;
            btb_wr_way   = head_pkt.way;
            btb_wr_tag   = head_pkt.tag;
            btb_wr_valid = (head_pkt.btb_act == BTB_ACT_ALLOC);
            btb_wr_tgt   = head_pkt.tgt;
            bht_wr_en    = wr_gnt;
            bht_wr_index = head_pkt.bht_idx;
            bht_wr_ctr   = head_pkt.ctr;
        end
    end
endmodule

// File: tb/tb_css_mcu0_el2_btb_update_ctl.sv
// Randomized and directed bench for the BTB/BHT training controller, checked against a
// queue-based reference model of the update and invalidate-sweep rules.
module tb_css_mcu0_el2_btb_update_ctl;
    logic        clk = 1'b0;
    logic        rst;
    logic        exu_br_valid;
    logic [31:0] br_addr;
    logic [30:0] exu_br_pc;
    logic [30:0] exu_br_tgt;
    logic        exu_br_taken;
    logic        exu_br_hit;
    logic [0:0]  exu_br_way;
    logic [1:0]  exu_br_ctr;
    logic [7:0]  exu_br_ghr;
    logic        inv_all_req;
    logic        wr_gnt;
    logic        wr_req, btb_wr_en, btb_wr_valid, bht_wr_en;
    logic [7:0]  btb_wr_index, bht_wr_index;
    logic [0:0]  btb_wr_way;
    logic [4:0]  btb_wr_tag;
    logic [30:0] btb_wr_tgt;
    logic [1:0]  bht_wr_ctr;
    logic        inv_busy, inv_done, upd_drop;

    always #5 clk = ~clk;
    assign exu_br_pc = br_addr[31:1];

    css_mcu0_el2_btb_update_ctl dut (
        .clk(clk), .rst(rst),
        .exu_br_valid(exu_br_valid), .exu_br_pc(exu_br_pc), .exu_br_tgt(exu_br_tgt),
        .exu_br_taken(exu_br_taken), .exu_br_hit(exu_br_hit), .exu_br_way(exu_br_way),
        .exu_br_ctr(exu_br_ctr), .exu_br_ghr(exu_br_ghr),
        .inv_all_req(inv_all_req), .wr_gnt(wr_gnt),
        .wr_req(wr_req), .btb_wr_en(btb_wr_en), .btb_wr_index(btb_wr_index),
        .btb_wr_way(btb_wr_way), .btb_wr_tag(btb_wr_tag), .btb_wr_valid(btb_wr_valid),
        .btb_wr_tgt(btb_wr_tgt), .bht_wr_en(bht_wr_en), .bht_wr_index(bht_wr_index),
        .bht_wr_ctr(bht_wr_ctr), .inv_busy(inv_busy), .inv_done(inv_done),
        .upd_drop(upd_drop)
    );

    typedef struct {
        logic [7:0]  idx;
        logic [4:0]  tag;
        logic [0:0]  way;
        logic [7:0]  bidx;
        logic [1:0]  ctr;
        bit          btbw;
        bit          vld;
        logic [30:0] tgt;
    } exp_t;

    exp_t q[$];
    bit   m_sweep, m_done, chk_en;
    int   m_idx, n_chk, n_fail, sweep_wr;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] f_idx(input logic [31:0] a);
        logic [31:0] t;
        t = (a >> 2) ^ (a >> 10) ^ (a >> 18);
        return t[7:0];
    endfunction

    function automatic logic [4:0] f_tag(input logic [31:0] a);
        logic [31:0] t;
        t = (a >> 10) ^ (a >> 15) ^ (a >> 20);
        return t[4:0];
    endfunction

    function automatic exp_t mk_pkt();
        exp_t p;
        int   c, n;
        c      = int'(exu_br_ctr);
        n      = exu_br_taken ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
        p.idx  = f_idx(br_addr);
        p.tag  = f_tag(br_addr);
        p.way  = exu_br_way;
        p.bidx = p.idx ^ exu_br_ghr;
        p.ctr  = 2'(n);
        p.btbw = exu_br_taken || (exu_br_hit && (n == 0));
        p.vld  = exu_br_taken;
        p.tgt  = exu_br_tgt;
        return p;
    endfunction

    function automatic bit head_vld();
        return !m_sweep && !m_done && (q.size() > 0);
    endfunction

    task automatic check_outputs();
        exp_t h;
        bit   hv, pop, entering, drop;
        hv       = head_vld();
        pop      = hv && wr_gnt;
        entering = inv_all_req && !m_sweep;
        drop     = exu_br_valid && !rst && (q.size() == 4) && !pop && !entering;
        if (btb_wr_en && inv_busy) sweep_wr++;
        check_val("wr_req", wr_req, m_sweep || hv);
        check_val("inv_busy", inv_busy, m_sweep);
        check_val("inv_done", inv_done, m_done);
        check_val("upd_drop", upd_drop, drop);
        if (m_sweep) begin
            check_val("swp_btb_en", btb_wr_en, wr_gnt);
            check_val("swp_bht_en", bht_wr_en, 1'b0);
            check_val("swp_index", btb_wr_index, m_idx);
            check_val("swp_valid", btb_wr_valid, 1'b0);
        end else if (hv) begin
            h = q[0];
            check_val("btb_en", btb_wr_en, wr_gnt && h.btbw);
            check_val("bht_en", bht_wr_en, wr_gnt);
            check_val("btb_index", btb_wr_index, h.idx);
            check_val("bht_index", bht_wr_index, h.bidx);
            check_val("bht_ctr", bht_wr_ctr, h.ctr);
            if (h.btbw) begin
                check_val("btb_tag", btb_wr_tag, h.tag);
                check_val("btb_way", btb_wr_way, h.way);
                check_val("btb_valid", btb_wr_valid, h.vld);
                if (h.vld) check_val("btb_tgt", btb_wr_tgt, h.tgt);
            end
        end else begin
            check_val("idle_btb_en", btb_wr_en, 1'b0);
            check_val("idle_bht_en", bht_wr_en, 1'b0);
        end
    endtask

    task automatic model_update();
        bit pop, entering;
        if (rst) begin
            q.delete();
            m_sweep = 0;
            m_done  = 0;
            m_idx   = 0;
            return;
        end
        pop      = head_vld() && wr_gnt;
        entering = inv_all_req && !m_sweep;
        if (m_sweep) begin
            if (inv_all_req) m_idx = 0;
            else if (wr_gnt) begin
                if (m_idx == 255) begin
                    m_sweep = 0;
                    m_done  = 1;
                end else m_idx++;
            end
        end else if (m_done) begin
            m_done = 0;
            if (inv_all_req) begin m_sweep = 1; m_idx = 0; q.delete(); end
        end else begin
            if (pop) void'(q.pop_front());
            if (inv_all_req) begin m_sweep = 1; m_idx = 0; q.delete(); end
        end
        if (exu_br_valid && (entering || q.size() < 4)) q.push_back(mk_pkt());
    endtask

    task automatic tick();
        #1;
        if (chk_en) check_outputs();
        model_update();
        @(negedge clk);
    endtask

    task automatic set_br(input bit v, input logic [31:0] a, input bit tk, input bit hit,
                          input logic [1:0] c);
        exu_br_valid = v;
        br_addr      = a;
        exu_br_taken = tk;
        exu_br_hit   = hit;
        exu_br_ctr   = c;
        exu_br_tgt   = 31'($urandom);
        exu_br_way   = 1'($urandom);
        exu_br_ghr   = 8'($urandom);
    endtask

    task automatic rand_br(input bit v);
        set_br(v, $urandom, 1'($urandom), 1'($urandom), 2'($urandom));
    endtask

    initial begin
        rst = 1'b1; inv_all_req = 1'b0; wr_gnt = 1'b0; chk_en = 1'b0;
        set_br(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        n_chk = 0; n_fail = 0; sweep_wr = 0;
        m_sweep = 0; m_done = 0; m_idx = 0;
        @(negedge clk);
        tick();
        // Reset: outputs quiet, and a report offered during reset is not queued.
        set_br(1'b1, 32'h8000_0100, 1'b1, 1'b0, 2'd1);
        wr_gnt = 1'b1;
        #1;
        check_val("rst_wr_req", wr_req, 1'b0);
        check_val("rst_btb_en", btb_wr_en, 1'b0);
        check_val("rst_bht_en", bht_wr_en, 1'b0);
        check_val("rst_busy", inv_busy, 1'b0);
        check_val("rst_done", inv_done, 1'b0);
        check_val("rst_drop", upd_drop, 1'b0);
        check_val("rst_index", {btb_wr_index, bht_wr_index, btb_wr_tag, btb_wr_way}, '0);
        check_val("rst_data", {btb_wr_tgt, btb_wr_valid, bht_wr_ctr}, '0);
        tick();
        tick();
        rst = 1'b0; chk_en = 1'b1;
        set_br(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        tick();

        // Taken miss allocates; written the cycle after the report.
        set_br(1'b1, 32'h8000_0100, 1'b1, 1'b0, 2'd1);
        tick();
        exu_br_valid = 1'b0;
        #1;
        check_val("t2_index", btb_wr_index, 8'h40);
        check_val("t2_tag", btb_wr_tag, 5'h00);
        check_val("t2_valid", btb_wr_valid, 1'b1);
        check_val("t2_ctr", bht_wr_ctr, 2'd2);
        tick();

        // Not-taken hit reaching zero invalidates; counter saturates at zero.
        set_br(1'b1, 32'h1234_5678, 1'b0, 1'b1, 2'd1);
        tick();
        set_br(1'b1, 32'h0BAD_F00C, 1'b0, 1'b0, 2'd0);
        tick();
        exu_br_valid = 1'b0;
        tick();
        tick();

        // Fill with no grant, overflow, push+pop when full, then drain in order.
        wr_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin rand_br(1'b1); tick(); end
        rand_br(1'b1); wr_gnt = 1'b1; tick();
        exu_br_valid = 1'b0; wr_gnt = 1'b0; tick();
        rand_br(1'b1); tick();
        exu_br_valid = 1'b0; wr_gnt = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Invalidate sweep with stale entries queued and a report arriving mid-sweep.
        wr_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin rand_br(1'b1); tick(); end
        exu_br_valid = 1'b0; inv_all_req = 1'b1; sweep_wr = 0;
        tick();
        inv_all_req = 1'b0; wr_gnt = 1'b1;
        for (int i = 0; i < 257; i++) begin
            rand_br(i == 100);
            tick();
        end
        check_val("sweep_beats", sweep_wr, 256);
        exu_br_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Reset in the middle of a sweep returns to idle without inv_done.
        inv_all_req = 1'b1; tick();
        inv_all_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_br($urandom_range(0, 1) == 1);
            wr_gnt      = ($urandom_range(0, 9) < 6);
            inv_all_req = ($urandom_range(0, 399) == 0);
            rst         = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0; inv_all_req = 1'b0; exu_br_valid = 1'b0; wr_gnt = 1'b1;
        for (int i = 0; i < 600; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
